apu_frame_sequencer: RTL and testbench

Frame-counter scheduler for the NES APU. It counts CPU-rate ticks and emits single-cycle quarter-frame and half-frame strobes that sequence the envelope, linear-counter, length-counter and sweep units. It also raises the frame IRQ. It sits between the tick edge detectors, which turn slow enable clocks into one-`iClk` pulses, and the channel units. It is configured by CPU writes to $4017.

---
 rtl/apu_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_apu_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/apu_frame_sequencer.sv
// NES APU frame counter: counts CPU ticks and emits registered quarter/half-frame
// strobes plus the level frame IRQ, reconfigured by writes to $4017.
module apu_frame_sequencer #(
    parameter int STEP1 = 7457,
    parameter int STEP2 = 14913,
    parameter int STEP3 = 22371,
    parameter int STEP4 = 29829,
    parameter int STEP5 = 37281,
    parameter int CNT_W = 16
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCpuTick,
    input  logic       iWrite4017,
    input  logic [7:0] iData,
    input  logic       iRead4015,
    output logic       oQuarterFrame,
    output logic       oHalfFrame,
    output logic       oFrameIrq,
    output logic       oMode
);

    typedef enum logic [2:0] {S0, S1, S2, S3, S4} step_t;

    localparam logic [CNT_W-1:0] STEP1_C = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] STEP2_C = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] STEP3_C = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] STEP4_C = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] STEP5_C = CNT_W'(STEP5);

    step_t            step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             inhibit_q, inhibit_d;
    logic             irq_q, irq_d;
    logic             pend_q, pend_d;
    logic             quarter_q, quarter_d;
    logic             half_q, half_d;

    logic             quarter_evt;
    logic             half_evt;
    logic             set_irq;
    logic [CNT_W-1:0] final_step;
    logic             unused_data;

    assign unused_data = ^iData[5:0];

    always_ff @(posedge iClk) begin
        if (iReset) begin
            step_q    <= S0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            irq_q     <= 1'b0;
            pend_q    <= 1'b0;
            quarter_q <= 1'b0;
            half_q    <= 1'b0;
        end else begin
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            irq_q     <= irq_d;
            pend_q    <= pend_d;
            quarter_q <= quarter_d;
            half_q    <= half_d;
        end
    end

    always_comb begin
        step_d      = step_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        inhibit_d   = inhibit_q;
        irq_d       = irq_q;
        pend_d      = pend_q;
        quarter_evt = 1'b0;
        half_evt    = 1'b0;
        set_irq     = 1'b0;
        final_step  = mode_q ? STEP5_C : STEP4_C;

        // A tick coinciding with a write is a normal tick; only later ticks consume pend.
        if (iCpuTick) begin
            if (pend_q && !iWrite4017) begin
                cnt_d  = '0;
                step_d = S0;
                pend_d = 1'b0;
                if (mode_q) begin
                    quarter_evt = 1'b1;
                    half_evt    = 1'b1;
                end
            end else begin
                cnt_d = (cnt_q >= final_step) ? '0 : cnt_q + 1'b1;
                if (cnt_q == STEP1_C) begin
                    quarter_evt = 1'b1;
                    step_d      = S1;
                end else if (cnt_q == STEP2_C) begin
                    quarter_evt = 1'b1;
                    half_evt    = 1'b1;
                    step_d      = S2;
                end else if (cnt_q == STEP3_C) begin
                    quarter_evt = 1'b1;
                    step_d      = S3;
                end else if (cnt_q == STEP4_C) begin
                    if (!mode_q) begin
                        quarter_evt = 1'b1;
                        half_evt    = 1'b1;
                        set_irq     = !inhibit_q;
                        step_d      = S0;
                    end else begin
                        step_d = S4;
                    end
                end else if (mode_q && (cnt_q == STEP5_C)) begin
                    quarter_evt = 1'b1;
                    half_evt    = 1'b1;
                    step_d      = S0;
                end
            end
        end

        if (iWrite4017) begin
            mode_d    = iData[7];
            inhibit_d = iData[6];
            pend_d    = 1'b1;
        end

        // Priority: acknowledge < IRQ set < inhibit write.
        if (iRead4015) irq_d = 1'b0;
        if (set_irq) irq_d = 1'b1;
        if (iWrite4017 && iData[6]) irq_d = 1'b0;

        quarter_d = quarter_evt && !quarter_q;
        half_d    = half_evt && !half_q;
    end

    always_comb begin
        oQuarterFrame = quarter_q;
        oHalfFrame    = half_q;
        oFrameIrq     = irq_q;
        oMode         = mode_q;
    end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer using shortened step positions
// (7/14/22/29/37) so full frame periods fit in a short run.
module tb_apu_frame_sequencer;

    logic       iClk = 1'b0;
    logic       iReset = 1'b0;
    logic       iCpuTick = 1'b0;
    logic       iWrite4017 = 1'b0;
    logic [7:0] iData = 8'h00;
    logic       iRead4015 = 1'b0;
    logic       oQuarterFrame;
    logic       oHalfFrame;
    logic       oFrameIrq;
    logic       oMode;

    int checks = 0;
    int errors = 0;
    int q_count;
    int h_count;

    apu_frame_sequencer #(
        .STEP1(7), .STEP2(14), .STEP3(22), .STEP4(29), .STEP5(37), .CNT_W(6)
    ) dut (
        .iClk         (iClk),
        .iReset       (iReset),
        .iCpuTick     (iCpuTick),
        .iWrite4017   (iWrite4017),
        .iData        (iData),
        .iRead4015    (iRead4015),
        .oQuarterFrame(oQuarterFrame),
        .oHalfFrame   (oHalfFrame),
        .oFrameIrq    (oFrameIrq),
        .oMode        (oMode)
    );

    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock with current inputs; sample 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge iClk);
        #1;
    endtask

    // n consecutive ticks; counts strobe cycles and flags back-to-back strobes.
    task automatic runTicks(input int n);
        logic prev_q;
        logic prev_h;
        prev_q   = oQuarterFrame;
        prev_h   = oHalfFrame;
        q_count  = 0;
        h_count  = 0;
        iCpuTick = 1'b1;
        for (int i = 0; i < n; i++) begin
            applyStimulus();
            if (oQuarterFrame) q_count++;
            if (oHalfFrame) h_count++;
            if (prev_q && oQuarterFrame) checkOutput("quarter_back_to_back", 1, 0);
            if (prev_h && oHalfFrame) checkOutput("half_back_to_back", 1, 0);
            prev_q = oQuarterFrame;
            prev_h = oHalfFrame;
        end
        iCpuTick = 1'b0;
    endtask

    initial begin
        // Reset state
        iReset = 1'b1;
        applyStimulus();
        applyStimulus();
        iReset = 1'b0;
        checkOutput("reset_quarter", oQuarterFrame, 0);
        checkOutput("reset_half", oHalfFrame, 0);
        checkOutput("reset_irq", oFrameIrq, 0);
        checkOutput("reset_mode", oMode, 0);

        // 4-step sequence from reset
        runTicks(7);
        checkOutput("pre_step1_quarters", q_count, 0);
        runTicks(1);
        checkOutput("step1_quarter", oQuarterFrame, 1);
        checkOutput("step1_half", oHalfFrame, 0);
        runTicks(7);
        checkOutput("step2_quarter", oQuarterFrame, 1);
        checkOutput("step2_half", oHalfFrame, 1);
        checkOutput("step2_q_count", q_count, 1);
        runTicks(8);
        checkOutput("step3_quarter", oQuarterFrame, 1);
        checkOutput("step3_half", oHalfFrame, 0);
        runTicks(7);
        checkOutput("step4_quarter", oQuarterFrame, 1);
        checkOutput("step4_half", oHalfFrame, 1);
        checkOutput("step4_irq", oFrameIrq, 1);
        checkOutput("step4_q_count", q_count, 1);
        applyStimulus();
        checkOutput("strobe_one_cycle", oQuarterFrame, 0);
        checkOutput("irq_holds", oFrameIrq, 1);

        // Acknowledge, then a full period to the next STEP4
        iRead4015 = 1'b1;
        applyStimulus();
        iRead4015 = 1'b0;
        checkOutput("ack_clears_irq", oFrameIrq, 0);
        runTicks(30);
        checkOutput("period_q_count", q_count, 4);
        checkOutput("period_h_count", h_count, 2);
        checkOutput("period_end_quarter", oQuarterFrame, 1);
        checkOutput("period_irq", oFrameIrq, 1);

        // Acknowledge in the STEP4 tick cycle loses to the set
        iRead4015 = 1'b1;
        applyStimulus();
        iRead4015 = 1'b0;
        checkOutput("ack2_clears_irq", oFrameIrq, 0);
        runTicks(29);
        iRead4015 = 1'b1;
        runTicks(1);
        iRead4015 = 1'b0;
        checkOutput("set_beats_ack", oFrameIrq, 1);

        // Inhibit write clears IRQ and blocks the next one
        iWrite4017 = 1'b1;
        iData      = 8'h40;
        applyStimulus();
        iWrite4017 = 1'b0;
        checkOutput("inhibit_clears_irq", oFrameIrq, 0);
        runTicks(1);
        checkOutput("pend_reset_mode0_no_strobe", oQuarterFrame, 0);
        runTicks(30);
        checkOutput("inhibited_q_count", q_count, 4);
        checkOutput("inhibited_irq", oFrameIrq, 0);

        // Inhibit write in the STEP4 tick cycle suppresses the set
        iWrite4017 = 1'b1;
        iData      = 8'h00;
        applyStimulus();
        iWrite4017 = 1'b0;
        runTicks(1);
        runTicks(29);
        iWrite4017 = 1'b1;
        iData      = 8'h40;
        runTicks(1);
        iWrite4017 = 1'b0;
        checkOutput("inhibit_step4_quarter", oQuarterFrame, 1);
        checkOutput("inhibit_step4_irq", oFrameIrq, 0);

        // 5-step mode: immediate strobes on the pending-reset tick
        iWrite4017 = 1'b1;
        iData      = 8'h80;
        applyStimulus();
        iWrite4017 = 1'b0;
        checkOutput("mode_after_write", oMode, 1);
        runTicks(1);
        checkOutput("mode1_immediate_quarter", oQuarterFrame, 1);
        checkOutput("mode1_immediate_half", oHalfFrame, 1);
        runTicks(37);
        checkOutput("mode1_q_count", q_count, 3);
        checkOutput("mode1_h_count", h_count, 1);
        runTicks(1);
        checkOutput("step5_quarter", oQuarterFrame, 1);
        checkOutput("step5_half", oHalfFrame, 1);
        checkOutput("mode1_irq", oFrameIrq, 0);

        // Write with a tick at STEP1: strobe still fires, counter resets on next tick
        runTicks(7);
        iWrite4017 = 1'b1;
        iData      = 8'h00;
        runTicks(1);
        iWrite4017 = 1'b0;
        checkOutput("write_tick_step1_quarter", oQuarterFrame, 1);
        checkOutput("write_tick_mode", oMode, 0);
        runTicks(1);
        checkOutput("pend_tick_no_strobe", oQuarterFrame, 0);
        runTicks(8);
        checkOutput("after_pend_q_count", q_count, 1);
        checkOutput("after_pend_step1", oQuarterFrame, 1);

        // Reset overrides a pending write and a same-cycle write/tick
        runTicks(12);
        iWrite4017 = 1'b1;
        iData      = 8'h80;
        applyStimulus();
        iData      = 8'hC0;
        iReset     = 1'b1;
        iCpuTick   = 1'b1;
        applyStimulus();
        iReset     = 1'b0;
        iWrite4017 = 1'b0;
        iCpuTick   = 1'b0;
        checkOutput("midreset_quarter", oQuarterFrame, 0);
        checkOutput("midreset_half", oHalfFrame, 0);
        checkOutput("midreset_irq", oFrameIrq, 0);
        checkOutput("midreset_mode", oMode, 0);
        runTicks(7);
        checkOutput("midreset_pre_step1", q_count, 0);
        runTicks(1);
        checkOutput("midreset_step1", oQuarterFrame, 1);

        // Sparse ticks: timing follows tick count, not clock count
        runTicks(6);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("idle_no_quarter", oQuarterFrame, 0);
        end
        runTicks(1);
        checkOutput("sparse_step2_quarter", oQuarterFrame, 1);
        checkOutput("sparse_step2_half", oHalfFrame, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
